// File: rtl/calc_cmd_pkg.sv
// Shared encodings for the calculator command arbiter: one-hot FSM states
// and the compute operation codes driven on CMD_OPERATION.
package calc_cmd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_ISSUE = 4'b0010,
      ST_WAIT  = 4'b0100,
      ST_ACK   = 4'b1000
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/calc_rr_pick.sv
// Round-robin first-set search: starting at i_ptr and wrapping upward,
// returns the index of the first pending request and whether any is pending.
module calc_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [IDW-1:0]     o_grant,
   output logic               o_any
);

   // Scan NUM_REQ positions from the pointer; the first hit wins.
   always_comb begin : p_search
      int unsigned idx;
      logic        found;
      found   = 1'b0;
      o_grant = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (int'(i_ptr) + i) % NUM_REQ;
         if (!found && i_req[idx]) begin
            found   = 1'b1;
            o_grant = IDW'(idx);
         end
      end
      o_any = found;
   end

endmodule

// File: rtl/calc_cmd_arbiter.sv
// Command arbiter for the shared BCD add/sub datapath. Round-robin grants
// one requester, issues a 1-cycle clear/compute pulse, waits for the
// datapath done pulse and acks the winner.
// Optional: define CMD_TIMEOUT_EN for a WAIT-state watchdog that acks with
// REQ_ERR after TIMEOUT_CYCLES cycles without CMD_DONE.
module calc_cmd_arbiter
   import calc_cmd_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [NUM_REQ-1:0] i_req_valid,
   input  logic [NUM_REQ-1:0] i_req_clear,
   input  logic [NUM_REQ-1:0] i_req_op,
   output logic [NUM_REQ-1:0] o_req_ack,
   output logic [NUM_REQ-1:0] o_req_err,
   output logic [IDW-1:0]     o_grant_id,
   output logic               o_busy,
   output logic               o_cmd_clear,
   output logic               o_cmd_compute,
   output logic               o_cmd_operation,
   input  logic               i_cmd_done
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("calc_cmd_arbiter: parameter out of range");
   end

   state_e               r_state, w_state_nxt;
   logic [IDW-1:0]       r_grant, w_grant_nxt;
   logic [IDW-1:0]       r_ptr, w_ptr_nxt;
   logic                 r_cmd_clear, w_cmd_clear_nxt;
   logic                 r_cmd_compute, w_cmd_compute_nxt;
   logic                 r_cmd_op, w_cmd_op_nxt;
   logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
   logic [IDW-1:0]       w_pick;
   logic                 w_any;

`ifdef CMD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [NUM_REQ-1:0]   r_err, w_err_nxt;
`endif

   calc_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick),
      .o_any   (w_any)
   );

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_ptr         <= '0;
         r_cmd_clear   <= 1'b0;
         r_cmd_compute <= 1'b0;
         r_cmd_op      <= OP_ADD;
         r_ack         <= '0;
`ifdef CMD_TIMEOUT_EN
         r_cnt         <= '0;
         r_err         <= '0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_ptr         <= w_ptr_nxt;
         r_cmd_clear   <= w_cmd_clear_nxt;
         r_cmd_compute <= w_cmd_compute_nxt;
         r_cmd_op      <= w_cmd_op_nxt;
         r_ack         <= w_ack_nxt;
`ifdef CMD_TIMEOUT_EN
         r_cnt         <= w_cnt_nxt;
         r_err         <= w_err_nxt;
`endif
      end
   end

   // Next-state and next-output decode; pulses default low, op/grant hold.
   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_ptr_nxt         = r_ptr;
      w_cmd_clear_nxt   = 1'b0;
      w_cmd_compute_nxt = 1'b0;
      w_cmd_op_nxt      = r_cmd_op;
      w_ack_nxt         = '0;
`ifdef CMD_TIMEOUT_EN
      w_cnt_nxt         = r_cnt;
      w_err_nxt         = '0;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_grant_nxt = w_pick;
               if (i_req_clear[w_pick]) begin
                  w_cmd_clear_nxt = 1'b1;
               end else begin
                  w_cmd_compute_nxt = 1'b1;
                  w_cmd_op_nxt      = i_req_op[w_pick];
               end
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT;
`ifdef CMD_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
         end
         ST_WAIT: begin
            if (i_cmd_done) begin
               w_ack_nxt[r_grant] = 1'b1;
               w_state_nxt        = ST_ACK;
            end
`ifdef CMD_TIMEOUT_EN
            else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_ack_nxt[r_grant] = 1'b1;
               w_err_nxt[r_grant] = 1'b1;
               w_state_nxt        = ST_ACK;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
`endif
         end
         ST_ACK: begin
            w_ptr_nxt   = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_req_ack       = r_ack;
   assign o_grant_id      = r_grant;
   assign o_busy          = (r_state != ST_IDLE);
   assign o_cmd_clear     = r_cmd_clear;
   assign o_cmd_compute   = r_cmd_compute;
   assign o_cmd_operation = r_cmd_op;
`ifdef CMD_TIMEOUT_EN
   assign o_req_err       = r_err;
`else
   assign o_req_err       = '0;
`endif

endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Directed bench for calc_cmd_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_calc_cmd_arbiter;
   import calc_cmd_pkg::*;

   logic       clk;
   logic       reset_n;
   logic [1:0] req_valid;
   logic [1:0] req_clear;
   logic [1:0] req_op;
   logic [1:0] req_ack;
   logic [1:0] req_err;
   logic [0:0] grant_id;
   logic       busy;
   logic       cmd_clear;
   logic       cmd_compute;
   logic       cmd_operation;
   logic       cmd_done;

   int n_checks = 0;
   int n_errors = 0;

   calc_cmd_arbiter #(
      .NUM_REQ        (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .i_clk           (clk),
      .i_reset_n       (reset_n),
      .i_req_valid     (req_valid),
      .i_req_clear     (req_clear),
      .i_req_op        (req_op),
      .o_req_ack       (req_ack),
      .o_req_err       (req_err),
      .o_grant_id      (grant_id),
      .o_busy          (busy),
      .o_cmd_clear     (cmd_clear),
      .o_cmd_compute   (cmd_compute),
      .o_cmd_operation (cmd_operation),
      .i_cmd_done      (cmd_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: request sampled at the next edge, done after
   // dly WAIT cycles, then request vector set to vld_after during ACK.
   task automatic txn(input logic [1:0] vld, input logic [1:0] clr, input logic [1:0] opv,
                      input int dly, input logic [1:0] vld_after,
                      input int exp_g, input logic exp_clr, input logic exp_op);
      req_valid = vld;
      req_clear = clr;
      req_op    = opv;
      tick();
      check("issue_clear", cmd_clear, exp_clr);
      check("issue_compute", cmd_compute, !exp_clr);
      check("issue_op", cmd_operation, exp_op);
      check("issue_grant", grant_id, exp_g);
      check("issue_busy", busy, 1);
      req_clear = ~clr;
      req_op    = ~opv;
      tick();
      check("wait_pulses", {cmd_clear, cmd_compute}, 0);
      check("wait_op_hold", cmd_operation, exp_op);
      for (int k = 1; k < dly; k++) tick();
      check("wait_no_ack", req_ack, 0);
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      check("ack", req_ack, 2'b01 << exp_g);
      check("ack_err", req_err, 0);
      req_valid = vld_after;
      tick();
      check("post_ack", req_ack, 0);
      check("post_busy", busy, 0);
   endtask

   initial begin
      // T1: reset while all requests pending
      reset_n   = 1'b0;
      req_valid = 2'b11;
      req_clear = 2'b00;
      req_op    = 2'b00;
      cmd_done  = 1'b0;
      tick();
      tick();
      check("rst_ack", req_ack, 0);
      check("rst_err", req_err, 0);
      check("rst_grant", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd", {cmd_clear, cmd_compute, cmd_operation}, 0);
      req_valid = 2'b00;
      reset_n   = 1'b1;
      tick();
      check("idle_no_req", busy, 0);

      // T2: single add from requester 0, done 3 cycles after pulse
      txn(2'b01, 2'b00, {1'b1, OP_ADD}, 3, 2'b00, 0, 1'b0, OP_ADD);

      // T3: clear has priority over op; op output unchanged
      txn(2'b10, 2'b10, 2'b10, 2, 2'b00, 1, 1'b1, OP_ADD);

      // T4: both held; grants alternate 0,1,0,1
      txn(2'b11, 2'b00, {OP_SUB, OP_ADD}, 2, 2'b11, 0, 1'b0, OP_ADD);
      txn(2'b11, 2'b00, {OP_SUB, OP_ADD}, 1, 2'b11, 1, 1'b0, OP_SUB);
      txn(2'b11, 2'b00, {OP_SUB, OP_ADD}, 4, 2'b11, 0, 1'b0, OP_ADD);
      txn(2'b11, 2'b00, {OP_SUB, OP_ADD}, 2, 2'b00, 1, 1'b0, OP_SUB);

      // T5: stray done in IDLE and ISSUE ignored
      cmd_done = 1'b1;
      tick();
      check("stray_idle_busy", busy, 0);
      check("stray_idle_ack", req_ack, 0);
      req_valid = 2'b01;
      req_clear = 2'b00;
      req_op    = 2'b01;
      tick();
      check("t5_compute", cmd_compute, 1);
      check("t5_op", cmd_operation, OP_SUB);
      tick();
      cmd_done = 1'b0;
      check("stray_issue_ack", req_ack, 0);
      check("stray_issue_busy", busy, 1);
      tick();
      check("stray_issue_ack2", req_ack, 0);
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      check("t5_ack", req_ack, 2'b01);
      tick();
      check("t5_idle", busy, 0);
      tick();
      check("held_regrant", cmd_compute, 1);
      check("held_grant_id", grant_id, 0);
      tick();
      check("held_wait_busy", busy, 1);
      // reset in WAIT aborts without ack
      reset_n = 1'b0;
      tick();
      check("rst_wait_busy", busy, 0);
      check("rst_wait_ack", req_ack, 0);
      check("rst_wait_cmd", {cmd_clear, cmd_compute, cmd_operation}, 0);
      req_valid = 2'b00;
      cmd_done  = 1'b1;
      tick();
      reset_n  = 1'b1;
      tick();
      cmd_done = 1'b0;
      check("post_rst_ack", req_ack, 0);
      check("post_rst_busy", busy, 0);

      // T6: no CMD_DONE
      req_valid = 2'b01;
      req_clear = 2'b00;
      req_op    = 2'b00;
      tick();
      check("t6_compute", cmd_compute, 1);
      tick();
`ifdef CMD_TIMEOUT_EN
      for (int k = 0; k < 7; k++) begin
         tick();
         check("to_early_ack", req_ack, 0);
      end
      tick();
      check("to_ack", req_ack, 2'b01);
      check("to_err", req_err, 2'b01);
      req_valid = 2'b00;
      tick();
      check("to_post_ack", {req_ack, req_err}, 0);
      check("to_post_busy", busy, 0);
`else
      for (int k = 0; k < 20; k++) tick();
      check("noto_busy", busy, 1);
      check("noto_ack", req_ack, 0);
      check("noto_err", req_err, 0);
      reset_n   = 1'b0;
      req_valid = 2'b00;
      tick();
      reset_n = 1'b1;
      tick();
      check("noto_rst_busy", busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
